// File: rtl/input_port.sv
// input_port: 2-flop synchronized, debounced 8-bit input feeding a 4x8 FIFO; ports clk, rst (async active-low), in, rd_en, out_en -> out {valid, overflow, count, 3'b0, head}, pending
module input_port #(
  parameter int DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in,
  input  logic        rd_en,
  input  logic        out_en,
  output logic [15:0] out,
  output logic        pending
);
  localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE - 1);
  logic [7:0] s1_q, s1_d, s2_q, s2_d, cand_q, cand_d, stable_q, stable_d, cnt_q, cnt_d;
  logic [1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;
  logic       ovf_q, ovf_d;
  logic [7:0] mem_q [4];
  logic [7:0] mem_d [4];
  logic       commit, pop, push;
  always_comb begin
    s1_d     = in;
    s2_d     = s1_q;
    cand_d   = s2_q;
    cnt_d    = (s2_q != cand_q) ? 8'd0 : (cnt_q < CNT_MAX) ? cnt_q + 8'd1 : cnt_q;
    commit   = (cnt_q == CNT_MAX) && (cand_q != stable_q);
    stable_d = commit ? cand_q : stable_q;
    pop      = rd_en && (count_q != 3'd0);
    push     = commit && ((count_q != 3'd4) || pop);
    wr_ptr_d = wr_ptr_q + {1'b0, push};
    rd_ptr_d = rd_ptr_q + {1'b0, pop};
    count_d  = count_q + {2'b00, push} - {2'b00, pop};
    ovf_d    = (commit && (count_q == 3'd4) && !rd_en) ? 1'b1 : rd_en ? 1'b0 : ovf_q;
    mem_d    = mem_q;
    if (push) mem_d[wr_ptr_q] = cand_q;
    pending  = count_q != 3'd0;
    out      = out_en ? {pending, ovf_q, count_q, 3'b000, pending ? mem_q[rd_ptr_q] : 8'h00} : 16'h0000;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q     <= 8'h00;
      s2_q     <= 8'h00;
      cand_q   <= 8'h00;
      stable_q <= 8'h00;
      cnt_q    <= 8'h00;
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
      ovf_q    <= 1'b0;
      mem_q    <= '{default: 8'h00};
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      cand_q   <= cand_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      mem_q    <= mem_d;
    end
  end
endmodule

// File: doc/input_port.md
INPUT_PORT -- requirements
Module: input_port

Interface
REQ-001 Parameter DEBOUNCE, default 4, meaning the number of consecutive clk cycles the synchronized input must hold one value before it is accepted (legal range 2..255).
REQ-002 Port clk  input  1  system clock, the 1 MHz CPU clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  reset, asynchronous, active-low; while low, all state is held at reset values.
REQ-004 Port in  input  8  external switch/pin byte, asynchronous to clk.
REQ-005 Port rd_en  input  1  controller pop strobe; sampled on the rising edge of clk.
REQ-006 Port out_en  input  1  bus drive enable from the controller.
REQ-007 Port out  output  16  bus word: {valid, overflow, count[2:0], 3'b000, data[7:0]}.
REQ-008 Port pending  output  1  high whenever the FIFO is non-empty; used as a polled status/interrupt flag.

Function
REQ-009 in SHALL pass through a 2-flop synchronizer (s1, s2) before any other use.
REQ-010 Debounce: if s2 != cand, then cand <= s2 and cnt <= 0; otherwise, if cnt < DEBOUNCE-1, then cnt++ (saturating at DEBOUNCE-1).
REQ-011 Commit: on an edge where cnt == DEBOUNCE-1 and cand != stable, the block SHALL set stable <= cand and issue a push of cand into the FIFO.
REQ-012 Latency: a clean input change that settles before edge E1 SHALL become readable after edge E(3+DEBOUNCE); with the default, that is edge E7.
REQ-013 An input glitch shorter than DEBOUNCE cycles at s2 SHALL NOT produce a push and SHALL NOT change stable.
REQ-014 A return of the input to the current stable value SHALL NOT push.
REQ-015 The FIFO SHALL be 4 entries deep, 8 bits wide, with 2-bit wrap-around read and write pointers and a 3-bit count (0..4).
REQ-016 Pop: on an edge with rd_en=1 and count>0, the head entry SHALL be removed; rd_en with count==0 SHALL be ignored, with no pointer or count change.
REQ-017 A push with count==4 and no simultaneous pop SHALL drop the byte, set the sticky overflow flag, and still update stable.
REQ-018 A simultaneous push and pop with count==4 SHALL perform both, leave count=4, and SHALL NOT set overflow.
REQ-019 A simultaneous push and pop with count==0 SHALL ignore the pop and perform the push (count becomes 1).
REQ-020 overflow SHALL clear on any edge with rd_en=1; if a dropped push occurs on the same edge, overflow SHALL remain set.
REQ-021 out is combinational: when out_en=1, out = {count!=0, overflow, count, 3'b000, head byte}, with the head byte forced to 0x00 when count==0; when out_en=0, out = 16'h0000.
REQ-022 pending SHALL equal (count != 0), registered-state-derived with no extra latency.
REQ-023 rd_en and a push SHALL be evaluated against the pre-edge count in every combination.

Reset
REQ-024 While rst=0: s1, s2, cand, and stable = 0x00; cnt = 0; pointers = 0; count = 0; overflow = 0; pending = 0; out = 0x0000 regardless of FIFO contents.
REQ-025 Reset asserted mid-operation SHALL discard all FIFO contents and any debounce in progress immediately (asynchronously).
REQ-026 After rst deasserts, an in value already equal to 0x00 SHALL NOT push; any other held value SHALL push exactly once, after 3+DEBOUNCE edges.

Verification
REQ-027 Scenario: reset, in=0xA5 held, out_en=1 -> out=0x0000 through edge 6, out=0x88A5 after edge 7, pending=1.
REQ-028 Scenario: stable=0xA5, in pulses to 0x5A for 3 cycles, then returns to 0xA5 -> no push, count unchanged.
REQ-029 Scenario: 5 distinct debounced bytes 0x01..0x05 with no pops -> count=4, overflow=1, out=0xE001; 4 pops return 0x01, 0x02, 0x03, 0x04; the first pop clears overflow.
REQ-030 Scenario: FIFO full and a commit coincides with rd_en -> head popped, new byte enqueued at the tail, count=4, overflow=0.
REQ-031 Scenario: rd_en pulsed with FIFO empty -> out=0x0000 with out_en=1, pointers unchanged, a following push reads back correctly.
REQ-032 Scenario: rst pulled low for half a clk period while count=3 -> count=0, pending=0, out=0x0000 at once, with no clock edge required.
